// File: rtl/decay_envelope_if.sv
// Note-control and sample-stream signals between the oscillator side and the decay envelope.
// The master drives the note and raw samples; the slave returns the decayed stream and status.
interface decay_envelope_if;
    logic        note_start;
    logic [5:0]  note_duration;
    logic        new_sample_in;
    logic [15:0] sample_in;
    logic [15:0] sample_out;
    logic        new_sample_out;
    logic [5:0]  duration;
    logic        busy;

    modport master (
        output note_start, note_duration, new_sample_in, sample_in,
        input  sample_out, new_sample_out, duration, busy
    );

    modport slave (
        input  note_start, note_duration, new_sample_in, sample_in,
        output sample_out, new_sample_out, duration, busy
    );
endinterface

// File: rtl/decay_envelope.sv
// Per-note amplitude envelope: full gain for a sustain window, then stepwise decay to silence.
// One registered output strobe per accepted input strobe so the echo stage sees a steady rate.
//
// state   | meaning
// IDLE    | no note, gain 0, samples pass through as silence
// SUSTAIN | gain 255, sustain counter counts samples down
// DECAY   | gain reduced by DECAY_STEP every DECAY_PERIOD samples
module decay_envelope #(
    parameter int SAMPLES_PER_UNIT = 16,
    parameter int DECAY_PERIOD     = 4,
    parameter int DECAY_STEP       = 1
) (
    input  logic clk,
    input  logic reset,
    decay_envelope_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SUSTAIN, DECAY} state_t;

    localparam logic [15:0] SPU      = 16'(SAMPLES_PER_UNIT);
    localparam logic [7:0]  PER_LOAD = 8'(DECAY_PERIOD);
    localparam logic [7:0]  STEP     = 8'(DECAY_STEP);

    state_t      state_q, state_d, st;
    logic [7:0]  gain_q, gain_d, g, g_dec;
    logic [15:0] sus_q, sus_d, sus;
    logic [7:0]  per_q, per_d, per;
    logic [5:0]  dur_q, dur_d;
    logic [15:0] sample_q, sample_d;
    logic        strobe_q;
    logic        armed_q;
    logic        start, take;
    logic signed [24:0] s_ext, g_ext, prod;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            gain_q   <= 8'd0;
            sus_q    <= 16'd0;
            per_q    <= 8'd0;
            dur_q    <= 6'd0;
            sample_q <= 16'd0;
            strobe_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gain_q   <= gain_d;
            sus_q    <= sus_d;
            per_q    <= per_d;
            dur_q    <= dur_d;
            sample_q <= sample_d;
            strobe_q <= take;
            armed_q  <= 1'b1;
        end
    end

    // A note_start takes effect before a coincident sample, so that sample sees the new note.
    always_comb begin
        start = bus.note_start & armed_q;
        take  = bus.new_sample_in & armed_q;
        st    = state_q;
        g     = gain_q;
        sus   = sus_q;
        per   = per_q;
        dur_d = dur_q;
        if (start) begin
            dur_d = bus.note_duration;
            g     = 8'hFF;
            per   = PER_LOAD;
            sus   = 16'(bus.note_duration) * SPU;
            st    = (bus.note_duration == 6'd0) ? DECAY : SUSTAIN;
        end
        state_d = st;
        gain_d  = g;
        sus_d   = sus;
        per_d   = per;
        g_dec   = (g > STEP) ? (g - STEP) : 8'd0;
        if (take) begin
            unique case (st)
                SUSTAIN: begin
                    if (sus <= 16'd1) begin
                        sus_d   = 16'd0;
                        per_d   = PER_LOAD;
                        state_d = DECAY;
                    end else begin
                        sus_d = sus - 16'd1;
                    end
                end
                DECAY: begin
                    if (per <= 8'd1) begin
                        per_d  = PER_LOAD;
                        gain_d = g_dec;
                        if (g_dec == 8'd0) state_d = IDLE;
                    end else begin
                        per_d = per - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Gain 255 stands in for unity; the shifted product always fits 16 bits.
    always_comb begin
        s_ext    = 25'($signed(bus.sample_in));
        g_ext    = $signed({17'd0, g});
        prod     = s_ext * g_ext;
        sample_d = take ? 16'(prod >>> 8) : sample_q;
    end

    assign bus.sample_out     = sample_q;
    assign bus.new_sample_out = strobe_q;
    assign bus.duration       = dur_q;
    assign bus.busy           = (state_q != IDLE);

endmodule
